// File: rtl/uc_sequencer.sv
// Microcode sequencer: fetches and decodes instructions, maps opcodes through the jump ROM,
// walks the microcode ROM and queues decoded uops for the execution unit. Define UC_WATCHDOG_EN for the runaway watchdog.
module uc_sequencer #(
    parameter int UOP_W      = 16,
    parameter int UADDR_W    = 8,
    parameter int EOL_BIT    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_UOPS   = 64
) (
    input  logic               clk,
    input  logic               rst,
    output logic               rqi_p,
    input  logic               aki_n,
    input  logic [31:0]        cmd,
    input  logic               flush_p,
    output logic [7:0]         jadr_p,
    input  logic [UADDR_W-1:0] jdata,
    output logic [UADDR_W-1:0] uadr_p,
    input  logic [UOP_W-1:0]   udata,
    output logic               rqx_p,
    input  logic               akx_n,
    output logic [UOP_W-1:0]   opout_p,
    output logic [3:0]         regsrc,
    output logic [3:0]         regdst,
    output logic [3:0]         aluop,
    output logic [15:0]        opimm,
    output logic               err_p
);
    localparam int ENT_W = UOP_W + 28;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] ST_REQ  = 3'd0;
    localparam logic [2:0] ST_JMP  = 3'd1;
    localparam logic [2:0] ST_JWT  = 3'd2;
    localparam logic [2:0] ST_UADR = 3'd3;
    localparam logic [2:0] ST_UVAL = 3'd4;

    logic [2:0]         state_r;
    logic               rqi_p_r;
    logic [7:0]         jadr_r;
    logic [UADDR_W-1:0] uip_r;
    logic [3:0]         src_r, dst_r, alu_r;
    logic [15:0]        imm_r;

    logic [7:0]         b0_s, b1_s, dec_op_s;
    logic [3:0]         dec_src_s, dec_dst_s, dec_alu_s;
    logic               ack_s, pop_s, full_s, push_s, eol_s, force_eol_s, seq_end_s;
    logic [UOP_W-1:0]   uop_s;
    logic [ENT_W-1:0]   entry_s, head_s;

    logic [ENT_W-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   fcnt_r;
    logic [ENT_W-1:0]   hold_r;

    assign b0_s = cmd[31:24];
    assign b1_s = cmd[23:16];

    // Instruction field decode, selected by the opcode class in b0[7:4]
    always_comb begin
        dec_op_s  = 8'h00;
        dec_src_s = 4'h0;
        dec_dst_s = 4'h0;
        dec_alu_s = 4'h0;
        case (b0_s[7:4])
            4'hC: dec_op_s = {b0_s[7:3], 1'b0, b1_s[1:0]};
            4'hD, 4'hE, 4'hF: dec_op_s = {b0_s[7:2], b1_s[7:6]};
            default: begin
                dec_op_s  = {b0_s[7:4], b0_s[1:0], b1_s[1:0]};
                dec_src_s = {b0_s[3], b1_s[7:5]};
                dec_dst_s = {b0_s[2], b1_s[4:2]};
                dec_alu_s = b0_s[7:4];
            end
        endcase
    end

    assign ack_s     = (state_r == ST_REQ) && rqi_p_r && !aki_n;
    assign full_s    = (fcnt_r == CNT_W'(FIFO_DEPTH));
    assign pop_s     = (fcnt_r != CNT_W'(0)) && !akx_n;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_s    = (state_r == ST_UVAL) && (!full_s || pop_s);
    assign eol_s     = udata[EOL_BIT];
    assign seq_end_s = eol_s || force_eol_s;

    // Outgoing uop with the end-of-sequence bit possibly forced by the watchdog
    always_comb begin
        uop_s          = udata;
        uop_s[EOL_BIT] = seq_end_s;
    end

    assign entry_s = {uop_s, src_r, dst_r, alu_r, imm_r};

    // Sequencer FSM: fetch/decode, jump-ROM lookup, microcode walk
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_REQ;
            rqi_p_r <= 1'b0;
            jadr_r  <= 8'h00;
            uip_r   <= '0;
            src_r   <= 4'h0;
            dst_r   <= 4'h0;
            alu_r   <= 4'h0;
            imm_r   <= 16'h0000;
        end else if (flush_p) begin
            state_r <= ST_REQ;
            rqi_p_r <= 1'b1;
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (ack_s) begin
                        jadr_r  <= dec_op_s;
                        src_r   <= dec_src_s;
                        dst_r   <= dec_dst_s;
                        alu_r   <= dec_alu_s;
                        imm_r   <= cmd[15:0];
                        rqi_p_r <= 1'b0;
                        state_r <= ST_JMP;
                    end else begin
                        rqi_p_r <= 1'b1;
                    end
                end
                ST_JMP:  state_r <= ST_JWT;
                ST_JWT: begin
                    uip_r   <= jdata;
                    state_r <= ST_UADR;
                end
                ST_UADR: state_r <= ST_UVAL;
                ST_UVAL: begin
                    if (push_s) begin
                        if (seq_end_s) begin
                            state_r <= ST_REQ;
                            rqi_p_r <= 1'b1;
                        end else begin
                            uip_r   <= uip_r + UADDR_W'(1);
                            state_r <= ST_UADR;
                        end
                    end
                end
                default: begin
                    state_r <= ST_REQ;
                    rqi_p_r <= 1'b0;
                end
            endcase
        end
    end

    // Uop FIFO storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (!rst && !flush_p && push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // FIFO pointers, occupancy and the last-seen head held while empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fcnt_r   <= '0;
            hold_r   <= '0;
        end else if (flush_p) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fcnt_r   <= '0;
            hold_r   <= head_s;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                hold_r   <= mem_r[rd_ptr_r];
            end
            case ({push_s, pop_s})
                2'b10:   fcnt_r <= fcnt_r + CNT_W'(1);
                2'b01:   fcnt_r <= fcnt_r - CNT_W'(1);
                default: fcnt_r <= fcnt_r;
            endcase
        end
    end

    assign head_s  = (fcnt_r != CNT_W'(0)) ? mem_r[rd_ptr_r] : hold_r;
    assign rqx_p   = (fcnt_r != CNT_W'(0));
    assign opout_p = head_s[ENT_W-1:28];
    assign regsrc  = head_s[27:24];
    assign regdst  = head_s[23:20];
    assign aluop   = head_s[19:16];
    assign opimm   = head_s[15:0];
    assign rqi_p   = rqi_p_r;
    assign jadr_p  = jadr_r;
    assign uadr_p  = uip_r;

`ifdef UC_WATCHDOG_EN
    localparam int WD_W = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1;
    logic [WD_W-1:0] ucnt_r;
    logic            err_r;

    assign force_eol_s = (state_r == ST_UVAL) && !eol_s && (ucnt_r == WD_W'(MAX_UOPS - 1));

    // Per-instruction uop counter and sticky runaway flag (flush leaves the flag alone)
    always_ff @(posedge clk) begin
        if (rst) begin
            ucnt_r <= '0;
            err_r  <= 1'b0;
        end else if (flush_p) begin
            ucnt_r <= '0;
        end else if (state_r == ST_JWT) begin
            ucnt_r <= '0;
        end else if (push_s && force_eol_s) begin
            err_r  <= 1'b1;
        end else if (push_s && !eol_s) begin
            ucnt_r <= ucnt_r + WD_W'(1);
        end
    end

    assign err_p = err_r;
`else
    assign force_eol_s = 1'b0;
    assign err_p       = 1'b0;
`endif

endmodule

// File: tb/tb_uc_sequencer.sv
// Self-checking bench for uc_sequencer: directed vectors, corner sequences and a
// randomized run scored against a queue-based reference model.
module tb_uc_sequencer;
    localparam int MAXU = 8;
`ifdef UC_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rqi_p, aki_n, flush_p, rqx_p, akx_n, err_p;
    logic [31:0] cmd;
    logic [7:0]  jadr_p, jdata, uadr_p;
    logic [15:0] udata, opout_p, opimm;
    logic [3:0]  regsrc, regdst, aluop;
    logic [43:0] head;

    int checks = 0;
    int errors = 0;
    logic [7:0]  jrom [256];
    logic [15:0] urom [256];
    logic [43:0] exp_q [$];
    bit sb_on  = 1'b0;
    bit rnd_ak = 1'b0;

    typedef struct {
        logic [31:0] c;
        logic [7:0]  op;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [3:0]  alu;
    } vec_t;
    vec_t vt [7];

    uc_sequencer #(.MAX_UOPS(MAXU)) dut (
        .clk(clk), .rst(rst), .rqi_p(rqi_p), .aki_n(aki_n), .cmd(cmd), .flush_p(flush_p),
        .jadr_p(jadr_p), .jdata(jdata), .uadr_p(uadr_p), .udata(udata),
        .rqx_p(rqx_p), .akx_n(akx_n), .opout_p(opout_p), .regsrc(regsrc), .regdst(regdst),
        .aluop(aluop), .opimm(opimm), .err_p(err_p)
    );

    assign head = {opout_p, regsrc, regdst, aluop, opimm};

    always #5 clk = ~clk;

    // Synchronous ROMs: data valid one cycle after the address
    always @(posedge clk) begin
        jdata <= jrom[jadr_p];
        udata <= urom[uadr_p];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ak) akx_n = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [31:0] c);
        int n = 0;
        while (rqi_p !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("issue_rqi", rqi_p, 1);
        cmd = c;
        aki_n = 1'b0;
        tick();
        aki_n = 1'b1;
        cmd = $urandom;
    endtask

    task automatic pop_expect(input string name, input logic [43:0] exp);
        int n = 0;
        while (rqx_p !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk(name, head, exp);
        akx_n = 1'b0;
        tick();
        akx_n = 1'b1;
    endtask

    // Reference model: decode by class arithmetic, then walk the ROM to the end of sequence
    task automatic model_expect(input logic [31:0] c);
        int b0, b1, cls, op, src, dst, alu, uip;
        logic [15:0] u;
        logic [27:0] f;
        b0 = int'(c[31:24]);
        b1 = int'(c[23:16]);
        cls = b0 / 16;
        src = 0; dst = 0; alu = 0;
        if (cls <= 11) begin
            op  = cls * 16 + (b0 % 4) * 4 + b1 % 4;
            src = ((b0 / 8) % 2) * 8 + b1 / 32;
            dst = ((b0 / 4) % 2) * 8 + (b1 / 4) % 8;
            alu = cls;
        end else if (cls == 12) begin
            op = (b0 / 8) * 8 + b1 % 4;
        end else begin
            op = (b0 / 4) * 4 + b1 / 64;
        end
        f = {src[3:0], dst[3:0], alu[3:0], c[15:0]};
        uip = int'(jrom[op]);
        for (int n = 0; n < 1000; n++) begin
            u = urom[uip];
            if (WD && !u[4] && n == MAXU - 1) u[4] = 1'b1;
            exp_q.push_back({u, f});
            if (u[4]) break;
            uip = (uip + 1) % 256;
        end
    endtask

    // Scoreboard: every uop taken by the execution unit must match the model queue
    always @(negedge clk) begin
        if (sb_on && rqx_p && !akx_n) begin
            if (exp_q.size() == 0) chk("sb_extra_uop", 0, 1);
            else chk("sb_uop", head, exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int seen;
        logic [15:0] u;
        rst = 1'b1; aki_n = 1'b1; akx_n = 1'b1; flush_p = 1'b0; cmd = 32'h0;
        for (int i = 0; i < 256; i++) begin
            jrom[i] = 8'h20;
            urom[i] = 16'h0A50;
        end
        vt[0] = '{32'h1234ABCD, 8'h18, 4'h1, 4'h5, 4'h1};
        vt[1] = '{32'hC5A61122, 8'hC2, 4'h0, 4'h0, 4'h0};
        vt[2] = '{32'hF3C00000, 8'hF3, 4'h0, 4'h0, 4'h0};
        vt[3] = '{32'hBFFF5555, 8'hBF, 4'hF, 4'hF, 4'hB};
        vt[4] = '{32'hD0400000, 8'hD1, 4'h0, 4'h0, 4'h0};
        vt[5] = '{32'h08E30001, 8'h03, 4'hF, 4'h0, 4'h0};
        vt[6] = '{32'hCF030000, 8'hCB, 4'h0, 4'h0, 4'h0};

        // Reset state
        repeat (3) tick();
        chk("rst_rqi", rqi_p, 0);
        chk("rst_rqx", rqx_p, 0);
        chk("rst_jadr", jadr_p, 0);
        chk("rst_uadr", uadr_p, 0);
        chk("rst_err", err_p, 0);
        chk("rst_head", head, 0);
        rst = 1'b0;
        tick();
        chk("rqi_after_rst", rqi_p, 1);

        // Basic two-uop sequence and ack-to-uop latency
        jrom[8'h18] = 8'h10;
        urom[8'h10] = 16'h0000;
        urom[8'h11] = 16'h0010;
        issue(32'h1234ABCD);
        chk("t1_jadr", jadr_p, 8'h18);
        repeat (3) tick();
        chk("t1_lat_early", rqx_p, 0);
        tick();
        chk("t1_lat", rqx_p, 1);
        pop_expect("t1_uop0", {16'h0000, 4'h1, 4'h5, 4'h1, 16'hABCD});
        pop_expect("t1_uop1", {16'h0010, 4'h1, 4'h5, 4'h1, 16'hABCD});
        chk("t1_rqi", rqi_p, 1);

        // Decode table: every opcode maps to a single EOL uop at 0x20
        for (int i = 0; i < 256; i++) jrom[i] = 8'h20;
        for (int i = 0; i < 7; i++) begin
            issue(vt[i].c);
            chk("tbl_jadr", jadr_p, vt[i].op);
            pop_expect("tbl_uop", {16'h0A50, vt[i].src, vt[i].dst, vt[i].alu, vt[i].c[15:0]});
        end

        // Backpressure: six uops into a four-entry FIFO
        jrom[8'h20] = 8'h30;
        for (int i = 0; i < 5; i++) urom[8'h30 + i] = 16'h1000 + 16'(i);
        urom[8'h35] = 16'h1015;
        issue(32'h20000000);
        repeat (30) tick();
        chk("t3_stall_rqi", rqi_p, 0);
        chk("t3_stall_uadr", uadr_p, 8'h34);
        for (int i = 0; i < 6; i++)
            pop_expect("t3_order", {urom[8'h30 + i], 4'h0, 4'h0, 4'h2, 16'h0000});
        repeat (10) tick();
        chk("t3_no_dup", rqx_p, 0);
        chk("t3_rqi", rqi_p, 1);

        // Flush with two uops queued and the sequence mid-flight
        issue(32'h20000000);
        repeat (6) tick();
        chk("t4_pre", rqx_p, 1);
        flush_p = 1'b1;
        tick();
        flush_p = 1'b0;
        chk("t4_rqx", rqx_p, 0);
        chk("t4_rqi", rqi_p, 1);
        akx_n = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rqx_p) seen++;
        end
        akx_n = 1'b1;
        chk("t4_stale", seen, 0);

        // Instruction acked in the flush cycle is dropped
        cmd = 32'h20000000;
        aki_n = 1'b0;
        flush_p = 1'b1;
        tick();
        aki_n = 1'b1;
        flush_p = 1'b0;
        chk("drop_rqi", rqi_p, 1);
        akx_n = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rqx_p) seen++;
        end
        akx_n = 1'b1;
        chk("drop_nouop", seen, 0);

        // Microcode address wrap
        jrom[8'h30] = 8'hFF;
        urom[8'hFF] = 16'h2000;
        urom[8'h00] = 16'h2010;
        issue(32'h30000000);
        pop_expect("t5_uop0", {16'h2000, 4'h0, 4'h0, 4'h3, 16'h0000});
        pop_expect("t5_uop1", {16'h2010, 4'h0, 4'h0, 4'h3, 16'h0000});
        chk("t5_uadr", uadr_p, 8'h00);
        chk("t5_rqi", rqi_p, 1);

`ifdef UC_WATCHDOG_EN
        // Runaway sequence cut at MAXU uops
        jrom[8'h50] = 8'h60;
        for (int i = 0; i < 16; i++) urom[8'h60 + i] = 16'h3000 + 16'(i);
        issue(32'h50000000);
        for (int i = 0; i < MAXU; i++)
            pop_expect("t6_uop", {16'h3000 + 16'(i) + ((i == MAXU - 1) ? 16'h0010 : 16'h0000),
                                  4'h0, 4'h0, 4'h5, 16'h0000});
        repeat (10) tick();
        chk("t6_count", rqx_p, 0);
        chk("t6_err", err_p, 1);
        issue(32'h30000000);
        pop_expect("t6_next0", {16'h2000, 4'h0, 4'h0, 4'h3, 16'h0000});
        pop_expect("t6_next1", {16'h2010, 4'h0, 4'h0, 4'h3, 16'h0000});
        chk("t6_err_sticky", err_p, 1);
`else
        chk("no_wd_err", err_p, 0);
`endif

        // Randomized run against the reference model
        for (int i = 0; i < 256; i++) begin
            jrom[i] = 8'($urandom);
            u = 16'($urandom);
            if (i % 8 == 7) u[4] = 1'b1;
            urom[i] = u;
        end
        sb_on = 1'b1;
        rnd_ak = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cmd = $urandom;
            model_expect(cmd);
            issue(cmd);
        end
        rnd_ak = 1'b0;
        akx_n = 1'b0;
        for (int n = 0; n < 500 && exp_q.size() != 0; n++) tick();
        chk("rnd_drain", exp_q.size(), 0);
        repeat (20) tick();
        chk("rnd_empty", rqx_p, 0);
        sb_on = 1'b0;
        akx_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
